// File: rtl/writeback_stage.sv
// MEM/WB stage: selects ALU/load/link result and drives the regfile write port.
// Ports: clk, rst_n, in_* from MEM, dmem_rvalid/rdata, flush -> RegWrite, rw, wdata, busy, retire_count.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rw,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_link_pc,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pend_rw;
  logic              pend_we;

  logic              commit;
  logic              cap;
  logic              c_we;
  logic [ADDR_W-1:0] c_rw;
  logic [DATA_W-1:0] c_data;

  logic idle, wait_ld, live, is_ld;

  assign idle     = (state == IDLE);
  assign wait_ld  = (state == WAIT_LOAD);
  assign live     = !flush;
  assign is_ld    = (in_wb_sel == SEL_LOAD);
  assign in_ready = idle;
  assign busy     = wait_ld;

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    cap     = 1'b0;
    c_we    = 1'b0;
    c_rw    = rw;
    c_data  = wdata;
    unique case (1'b1)
      flush: begin
        state_n = IDLE;
      end
      live && idle && in_valid && is_ld: begin
        state_n = WAIT_LOAD;
        cap     = 1'b1;
      end
      live && idle && in_valid && !is_ld: begin
        commit = 1'b1;
        c_we   = in_reg_write;
        c_rw   = in_rw;
        c_data = (in_wb_sel == SEL_LINK)
               ? in_link_pc : in_alu_result;
      end
      live && wait_ld && dmem_rvalid: begin
        state_n = IDLE;
        commit  = 1'b1;
        c_we    = pend_we;
        c_rw    = pend_rw;
        c_data  = dmem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_rw      <= '0;
      pend_we      <= 1'b0;
      RegWrite     <= 1'b0;
      rw           <= '0;
      wdata        <= '0;
      retire_count <= '0;
    end else begin
      state    <= state_n;
      // $0 is hardwired; suppress the enable but still retire.
      RegWrite <= commit && c_we && (c_rw != '0);
      if (cap) begin
        pend_rw <= in_rw;
        pend_we <= in_reg_write;
      end
      if (commit) begin
        rw           <= c_rw;
        wdata        <= c_data;
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage.
// Stimulus pushes expected commits; a negedge monitor pops on each retire.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rw;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_link_pc;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic        RegWrite;
  logic [4:0]  rw;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] retire_count;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rw(in_rw),
    .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result),
    .in_link_pc(in_link_pc),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .flush(flush), .RegWrite(RegWrite),
    .rw(rw), .wdata(wdata), .busy(busy),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 0;
  logic [31:0] last_cnt = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(logic we, logic [4:0] r,
                      logic [31:0] d);
    exp_t e;
    exp_cnt++;
    e.we = we && (r != 5'd0);
    e.rw = r;
    e.data = d;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_cnt = 0;
    end else if (retire_count !== last_cnt) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: cnt %h", retire_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (RegWrite !== e.we || rw !== e.rw ||
            wdata !== e.data || retire_count !== e.cnt) begin
          failures++;
          $display("FAIL commit: got we=%b rw=%0d d=%h c=%0d want we=%b rw=%0d d=%h c=%0d",
                   RegWrite, rw, wdata, retire_count,
                   e.we, e.rw, e.data, e.cnt);
        end
      end
      last_cnt = retire_count;
    end else if (RegWrite !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL stray_regwrite: got %b want 0", RegWrite);
    end
  end

  task automatic issue(logic we, logic [4:0] r,
                       logic [1:0] sel, logic [31:0] alu,
                       logic [31:0] pc);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_reg_write = we;
    in_rw = r;
    in_wb_sel = sel;
    in_alu_result = alu;
    in_link_pc = pc;
    if (sel != 2'b01)
      push(we, r, (sel == 2'b10) ? pc : alu);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_reg_write = 0; in_rw = 0;
    in_wb_sel = 0; in_alu_result = 0; in_link_pc = 0;
    dmem_rvalid = 0; dmem_rdata = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", {31'b0, RegWrite}, 0);
    chk("rst_rw", {27'b0, rw}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnt", retire_count, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;

    issue(1, 5'd5, 2'b00, 32'h0000_1234, 32'h0);
    idle();
    chk("alu_cnt", retire_count, 1);
    chk("alu_rw", {27'b0, rw}, 5);
    @(posedge clk); #1;
    chk("pulse_drop", {31'b0, RegWrite}, 0);

    issue(1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0);
    issue(0, 5'd7, 2'b11, 32'h0000_A5A5, 32'h1111);
    idle();

    issue(1, 5'd8, 2'b01, 32'h0BAD_0BAD, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ld_busy", {31'b0, busy}, 1);
      chk("ld_ready", {31'b0, in_ready}, 0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    push(1, 5'd8, 32'hDEAD_BEEF);
    idle();
    chk("ld_ready_after", {31'b0, in_ready}, 1);
    chk("ld_wdata", wdata, 32'hDEAD_BEEF);

    issue(1, 5'd9, 2'b01, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_regwrite", {31'b0, RegWrite}, 0);
    chk("fl_cnt", retire_count, 4);
    chk("fl_ready", {31'b0, in_ready}, 1);
    chk("fl_busy", {31'b0, busy}, 0);
    dmem_rvalid = 1'b0;
    in_valid = 1'b1;
    in_reg_write = 1'b1;
    in_rw = 5'd3;
    in_wb_sel = 2'b00;
    in_alu_result = 32'h3333_3333;
    @(posedge clk); #1;
    chk("fl_accept_cnt", retire_count, 4);
    chk("fl_accept_rw", {27'b0, rw}, 8);
    flush = 1'b0;
    in_valid = 1'b0;

    issue(1, 5'd1, 2'b00, 32'h0000_0011, 32'h0);
    issue(1, 5'd2, 2'b10, 32'h0000_0022, 32'h0000_2020);
    issue(1, 5'd3, 2'b00, 32'h0000_0033, 32'h0);
    issue(1, 5'd4, 2'b10, 32'h0000_0044, 32'h0040_0010);
    idle();
    chk("b2b_regwrite", {31'b0, RegWrite}, 1);
    chk("b2b_wdata", wdata, 32'h0040_0010);
    chk("b2b_cnt", retire_count, 8);

    issue(1, 5'd10, 2'b01, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_busy_pre", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_cnt", retire_count, 0);
    chk("ar_regwrite", {31'b0, RegWrite}, 0);
    chk("ar_wdata", wdata, 0);
    chk("ar_ready", {31'b0, in_ready}, 1);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(1, 5'd12, 2'b00, 32'h0000_C0DE, 32'h0);
    idle();
    chk("post_rst_cnt", retire_count, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim exceeded limit");
    $fatal(1);
  end

endmodule
